// File: rtl/ctrl_word_uart_tx.sv
// rtl/ctrl_word_uart_tx.sv - serializes captured control words to a UART 8N1 line, LSB byte first
//
// Ports:
//   clk, rst            system clock, asynchronous active-high reset
//   cmd_valid, cmd_data one-cycle pulse and the control word it marks
//   int_cfg             interrupt config; bit0 enables the completion irq
//   irq_ack             clears irq and overrun
//   uart_tx             serial line, idles high
//   busy                frame in flight or holding buffer occupied
//   irq                 sticky word-completion interrupt
//   overrun             sticky flag, a word was dropped
module ctrl_word_uart_tx #(
  parameter int DATA_WIDTH   = 32,
  parameter int CLK_FREQ     = 50000000,
  parameter int BAUD         = 115200,
  parameter int CLKS_PER_BIT = CLK_FREQ / BAUD
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  cmd_valid,
  input  logic [DATA_WIDTH-1:0] cmd_data,
  input  logic [DATA_WIDTH-1:0] int_cfg,
  input  logic                  irq_ack,
  output logic                  uart_tx,
  output logic                  busy,
  output logic                  irq,
  output logic                  overrun
);

  localparam int NBYTES = DATA_WIDTH / 8;
  localparam int BYTE_W = (NBYTES > 1) ? $clog2(NBYTES) : 1;
  localparam int BAUD_W = $clog2(CLKS_PER_BIT);
  localparam logic [BYTE_W-1:0] LAST_BYTE = BYTE_W'(NBYTES - 1);
  localparam logic [BAUD_W-1:0] LAST_TICK = BAUD_W'(CLKS_PER_BIT - 1);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t                state_q, state_n;
  logic [DATA_WIDTH-1:0] shift_q, shift_n;
  logic [DATA_WIDTH-1:0] hold_q, hold_n;
  logic                  hold_full_q, hold_full_n;
  logic [BYTE_W-1:0]     byte_q, byte_n;
  logic [2:0]            bit_q, bit_n;
  logic [BAUD_W-1:0]     baud_q, baud_n;
  logic                  tx_n, busy_n, irq_n, overrun_n;
  logic                  word_done, hold_free, direct_load, drop;

  logic unused_cfg;
  assign unused_cfg = ^int_cfg[DATA_WIDTH-1:1];

  always_comb begin
    state_n     = state_q;
    shift_n     = shift_q;
    hold_n      = hold_q;
    hold_full_n = hold_full_q;
    byte_n      = byte_q;
    bit_n       = bit_q;
    baud_n      = baud_q;
    word_done   = 1'b0;
    hold_free   = 1'b0;
    direct_load = 1'b0;
    drop        = 1'b0;

    case (state_q)
      IDLE: begin
        if (cmd_valid) begin
          shift_n = cmd_data;
          byte_n  = '0;
          baud_n  = '0;
          state_n = START;
        end
      end
      START: begin
        if (baud_q == LAST_TICK) begin
          baud_n  = '0;
          bit_n   = 3'd0;
          state_n = DATA;
        end else begin
          baud_n = baud_q + 1'b1;
        end
      end
      DATA: begin
        if (baud_q == LAST_TICK) begin
          baud_n  = '0;
          // Bytes and bits both go out LSB first, so the whole word is one
          // right shift: the next line bit is always shift[0].
          shift_n = shift_q >> 1;
          if (bit_q == 3'd7) begin
            state_n = STOP;
          end else begin
            bit_n = bit_q + 3'd1;
          end
        end else begin
          baud_n = baud_q + 1'b1;
        end
      end
      STOP: begin
        if (baud_q == LAST_TICK) begin
          baud_n = '0;
          if (byte_q != LAST_BYTE) begin
            byte_n  = byte_q + 1'b1;
            state_n = START;
          end else begin
            word_done = 1'b1;
            byte_n    = '0;
            if (hold_full_q) begin
              shift_n   = hold_q;
              hold_free = 1'b1;
              state_n   = START;
            end else if (cmd_valid) begin
              // Word arriving exactly as the line frees up: start it
              // straight away instead of parking it in an empty hold.
              shift_n     = cmd_data;
              direct_load = 1'b1;
              state_n     = START;
            end else begin
              state_n = IDLE;
            end
          end
        end else begin
          baud_n = baud_q + 1'b1;
        end
      end
      default: state_n = IDLE;
    endcase

    if (hold_free) begin
      hold_full_n = 1'b0;
    end
    // A slot freed by this cycle's hold-to-shift transfer may be refilled.
    if (cmd_valid && (state_q != IDLE) && !direct_load) begin
      if (!hold_full_q || hold_free) begin
        hold_n      = cmd_data;
        hold_full_n = 1'b1;
      end else begin
        drop = 1'b1;
      end
    end

    // Sets take priority over a coincident acknowledge.
    irq_n = irq;
    if (irq_ack) irq_n = 1'b0;
    if (word_done && int_cfg[0]) irq_n = 1'b1;

    overrun_n = overrun;
    if (irq_ack) overrun_n = 1'b0;
    if (drop) overrun_n = 1'b1;

    case (state_n)
      START:   tx_n = 1'b0;
      DATA:    tx_n = shift_n[0];
      default: tx_n = 1'b1;
    endcase
    busy_n = (state_n != IDLE) | hold_full_n;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      shift_q     <= '0;
      hold_q      <= '0;
      hold_full_q <= 1'b0;
      byte_q      <= '0;
      bit_q       <= 3'd0;
      baud_q      <= '0;
      uart_tx     <= 1'b1;
      busy        <= 1'b0;
      irq         <= 1'b0;
      overrun     <= 1'b0;
    end else begin
      state_q     <= state_n;
      shift_q     <= shift_n;
      hold_q      <= hold_n;
      hold_full_q <= hold_full_n;
      byte_q      <= byte_n;
      bit_q       <= bit_n;
      baud_q      <= baud_n;
      uart_tx     <= tx_n;
      busy        <= busy_n;
      irq         <= irq_n;
      overrun     <= overrun_n;
    end
  end

endmodule

// File: tb/tb_ctrl_word_uart_tx.sv
// tb/tb_ctrl_word_uart_tx.sv - self-checking bench for ctrl_word_uart_tx
module tb_ctrl_word_uart_tx;

  localparam int MAXC = 2000;
  localparam int WORD = 160;

  logic        clk, rst, cmd_valid, irq_ack;
  logic [31:0] cmd_data, int_cfg;
  logic        uart_tx, busy, irq, overrun;

  ctrl_word_uart_tx #(
    .DATA_WIDTH(32), .CLK_FREQ(1000000), .BAUD(250000)
  ) dut (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_data(cmd_data),
    .int_cfg(int_cfg), .irq_ack(irq_ack), .uart_tx(uart_tx), .busy(busy),
    .irq(irq), .overrun(overrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int npass = 0;
  int ntotal = 0;

  logic        vld_at [MAXC];
  logic [31:0] data_at[MAXC];
  logic        ack_at [MAXC];
  logic        tx_log [MAXC];
  logic        busy_log[MAXC];
  logic        irq_log[MAXC];
  logic        ovr_log[MAXC];
  logic        in_win [MAXC];
  logic        cfg_bit;

  int          exp_s[$];
  int          exp_p[$];
  logic [31:0] exp_w[$];
  int          ndrop;

  task automatic chkv(input string tag, input logic [159:0] obs, input logic [159:0] exp);
    ntotal++;
    assert (obs === exp) npass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic chkb(input string tag, input logic obs, input logic exp);
    ntotal++;
    assert (obs === exp) npass++;
    else $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
  endtask

  // Expected line waveform of one word: 4 bytes x (start, 8 data, stop) x 4 cycles.
  function automatic logic [159:0] frame(input logic [31:0] w);
    logic [159:0] f;
    int bp, b, p;
    for (int k = 0; k < WORD; k++) begin
      bp = k / 4;
      b  = bp / 10;
      p  = bp % 10;
      if (p == 0)      f[k] = 1'b0;
      else if (p == 9) f[k] = 1'b1;
      else             f[k] = w[b*8 + p - 1];
    end
    return f;
  endfunction

  task automatic clear_sched();
    for (int c = 0; c < MAXC; c++) begin
      vld_at[c]  = 1'b0;
      data_at[c] = '0;
      ack_at[c]  = 1'b0;
    end
  endtask

  // Word-level model: a pulse is dropped only if an earlier word is still
  // waiting for a start more than one cycle away; otherwise it starts as soon
  // as both its own latency and the previous word's 160 cycles allow.
  task automatic build_model();
    int last_s, s;
    bit dropped;
    exp_s.delete(); exp_p.delete(); exp_w.delete();
    ndrop  = 0;
    last_s = -1000;
    for (int c = 0; c < MAXC; c++) begin
      if (vld_at[c]) begin
        dropped = 0;
        foreach (exp_s[j]) if (exp_p[j] < c && exp_s[j] > c + 1) dropped = 1;
        if (dropped) ndrop++;
        else begin
          s = (c + 1 > last_s + WORD) ? c + 1 : last_s + WORD;
          exp_s.push_back(s); exp_p.push_back(c); exp_w.push_back(data_at[c]);
          last_s = s;
        end
      end
    end
  endtask

  task automatic run(input int n);
    logic [31:0] r;
    for (int c = 0; c < MAXC; c++) begin
      tx_log[c] = 1'bx; busy_log[c] = 1'bx; irq_log[c] = 1'bx; ovr_log[c] = 1'bx;
    end
    for (int c = 0; c < n; c++) begin
      #1;
      cmd_valid = vld_at[c];
      r = $urandom;
      cmd_data = vld_at[c] ? data_at[c] : r;
      irq_ack = ack_at[c];
      r = $urandom;
      int_cfg = {r[31:1], cfg_bit};
      @(negedge clk);
      tx_log[c] = uart_tx; busy_log[c] = busy; irq_log[c] = irq; ovr_log[c] = overrun;
      @(posedge clk);
    end
    #1;
    cmd_valid = 1'b0;
    irq_ack   = 1'b0;
  endtask

  task automatic check_frames(input string tag, input int n);
    logic [159:0] o;
    int bad;
    for (int c = 0; c < MAXC; c++) in_win[c] = 1'b0;
    foreach (exp_s[i]) begin
      for (int k = 0; k < WORD; k++) begin
        o[k] = (exp_s[i] + k < MAXC) ? tx_log[exp_s[i] + k] : 1'bx;
        if (exp_s[i] + k < MAXC) in_win[exp_s[i] + k] = 1'b1;
      end
      chkv($sformatf("%s_w%0d", tag, i), o, frame(exp_w[i]));
    end
    bad = 0;
    for (int c = 0; c < n; c++) if (!in_win[c] && tx_log[c] !== 1'b1) bad++;
    chkv({tag, "_idle"}, 160'(bad), 160'd0);
  endtask

  function automatic int count_ovr(input int from, input int to);
    int n = 0;
    for (int c = from; c < to; c++) if (ovr_log[c] !== 1'b0) n++;
    return n;
  endfunction

  function automatic int count_irq(input int from, input int to);
    int n = 0;
    for (int c = from; c < to; c++) if (irq_log[c] !== 1'b0) n++;
    return n;
  endfunction

  initial begin
    int cyc, gap, nrun;
    rst = 1'b1; cmd_valid = 1'b0; cmd_data = '0; int_cfg = '0; irq_ack = 1'b0;
    cfg_bit = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chkb("rst_tx", uart_tx, 1'b1);
    chkb("rst_busy", busy, 1'b0);
    chkb("rst_irq", irq, 1'b0);
    chkb("rst_ovr", overrun, 1'b0);
    rst = 1'b0;

    // 1: reset in the middle of byte 2's data bits of an all-zero word
    clear_sched();
    vld_at[0] = 1'b1; data_at[0] = 32'h0;
    run(91);
    chkb("t1_pre_tx", uart_tx, 1'b0);
    chkb("t1_pre_busy", busy, 1'b1);
    rst = 1'b1;
    #1;
    chkb("t1_rst_tx", uart_tx, 1'b1);
    chkb("t1_rst_busy", busy, 1'b0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    clear_sched();
    vld_at[0] = 1'b1; data_at[0] = 32'h0000_00FF;
    build_model();
    run(170);
    check_frames("t1_after", 170);

    // 2: single word, irq and busy timing
    cfg_bit = 1'b1;
    clear_sched();
    vld_at[0] = 1'b1; data_at[0] = 32'hA5C3_0F81;
    build_model();
    run(170);
    chkb("t2_tx_c0", tx_log[0], 1'b1);
    chkb("t2_tx_c1", tx_log[1], 1'b0);
    check_frames("t2", 170);
    chkb("t2_busy_c1", busy_log[1], 1'b1);
    chkb("t2_busy_c160", busy_log[160], 1'b1);
    chkb("t2_busy_c161", busy_log[161], 1'b0);
    chkb("t2_irq_c160", irq_log[160], 1'b0);
    chkb("t2_irq_c161", irq_log[161], 1'b1);

    // 3: buffered back-to-back
    clear_sched();
    vld_at[0] = 1'b1; data_at[0] = 32'h1111_1111;
    vld_at[20] = 1'b1; data_at[20] = 32'h2222_2222;
    build_model();
    run(330);
    check_frames("t3", 330);
    chkv("t3_ovr_cycles", 160'(count_ovr(0, 330)), 160'd0);
    chkb("t3_busy_c320", busy_log[320], 1'b1);
    chkb("t3_busy_c321", busy_log[321], 1'b0);

    // 4: overrun on the third pulse
    clear_sched();
    vld_at[0] = 1'b1; data_at[0] = 32'h01;
    vld_at[10] = 1'b1; data_at[10] = 32'h02;
    vld_at[20] = 1'b1; data_at[20] = 32'h03;
    build_model();
    run(330);
    check_frames("t4", 330);
    chkb("t4_ovr_c20", ovr_log[20], 1'b0);
    chkb("t4_ovr_c21", ovr_log[21], 1'b1);
    chkb("t4_ovr_c329", ovr_log[329], 1'b1);

    // 5: third pulse on the cycle word 1's last stop bit ends
    clear_sched();
    ack_at[0] = 1'b1;
    vld_at[0] = 1'b1;   data_at[0] = $urandom;
    vld_at[10] = 1'b1;  data_at[10] = $urandom;
    vld_at[160] = 1'b1; data_at[160] = $urandom;
    build_model();
    run(490);
    check_frames("t5", 490);
    chkv("t5_ovr_cycles", 160'(count_ovr(1, 490)), 160'd0);

    // 6a: irq disabled at completion; ack clears the earlier irq
    cfg_bit = 1'b0;
    clear_sched();
    ack_at[0] = 1'b1;
    vld_at[0] = 1'b1; data_at[0] = $urandom;
    build_model();
    run(170);
    chkb("t6a_irq_c0", irq_log[0], 1'b1);
    chkv("t6a_irq_cycles", 160'(count_irq(1, 170)), 160'd0);

    // 6b: ack coincides with the completion set
    cfg_bit = 1'b1;
    clear_sched();
    vld_at[0] = 1'b1; data_at[0] = $urandom;
    ack_at[160] = 1'b1;
    build_model();
    run(170);
    chkb("t6b_irq_c160", irq_log[160], 1'b0);
    chkb("t6b_irq_c161", irq_log[161], 1'b1);
    chkb("t6b_irq_c169", irq_log[169], 1'b1);

    // 6c: a later ack clears both irq and overrun
    cfg_bit = 1'b0;
    clear_sched();
    vld_at[0] = 1'b1; data_at[0] = $urandom;
    vld_at[5] = 1'b1; data_at[5] = $urandom;
    vld_at[8] = 1'b1; data_at[8] = $urandom;
    ack_at[100] = 1'b1;
    build_model();
    run(330);
    check_frames("t6c", 330);
    chkb("t6c_ovr_c8", ovr_log[8], 1'b0);
    chkb("t6c_ovr_c9", ovr_log[9], 1'b1);
    chkb("t6c_irq_c100", irq_log[100], 1'b1);
    chkb("t6c_ovr_c100", ovr_log[100], 1'b1);
    chkb("t6c_irq_c101", irq_log[101], 1'b0);
    chkb("t6c_ovr_c101", ovr_log[101], 1'b0);
    chkv("t6c_irq_after", 160'(count_irq(101, 330)), 160'd0);

    // 7: randomized pulse trains against the word-level model
    cfg_bit = 1'b1;
    clear_sched();
    ack_at[0] = 1'b1;
    cyc = 0;
    for (int i = 0; i < 10; i++) begin
      vld_at[cyc] = 1'b1;
      data_at[cyc] = $urandom;
      case ($urandom_range(0, 2))
        0:       gap = $urandom_range(1, 3);
        1:       gap = $urandom_range(100, 170);
        default: gap = $urandom_range(150, 165);
      endcase
      cyc += gap;
    end
    build_model();
    nrun = exp_s[exp_s.size() - 1] + WORD + 5;
    if (nrun > MAXC) nrun = MAXC;
    run(nrun);
    check_frames("t7", nrun);
    chkb("t7_ovr_end", ovr_log[nrun - 1], (ndrop > 0));
    chkb("t7_busy_end", busy_log[nrun - 1], 1'b0);

    $display("%0d/%0d checks passed", npass, ntotal);
    $finish;
  end

endmodule
